// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: beats fill a shadow bank that is swapped into the active bank on ce.
// Define FIR_COEFF_SYMMETRIC_EN to load only (N_TAPS+1)/2 beats and mirror them across the centre tap.
module fir_coeff_loader #(
    parameter int N_TAPS  = 33,
    parameter int COEFF_W = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        ce,
    input  logic                        is_coeff_valid,
    output logic                        os_coeff_ready,
    input  logic [COEFF_W-1:0]          is32_coeff_data,
    input  logic                        is_coeff_last,
    input  logic                        i_abort,
    output logic [N_TAPS*COEFF_W-1:0]   om_coeff,
    output logic                        o_update,
    output logic                        o_load_err,
    output logic [7:0]                  o8_update_cnt
);

    localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int SET_LEN = (N_TAPS + 1) / 2;
`else
    localparam int SET_LEN = N_TAPS;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COEFF_W-1:0]   shadow_q [N_TAPS];
    logic [COEFF_W-1:0]   shadow_d [N_TAPS];
    logic [COEFF_W-1:0]   active_q [N_TAPS];
    logic [COEFF_W-1:0]   active_d [N_TAPS];
    logic                 update_q, update_d;
    logic                 err_q, err_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 xfer;

    assign os_coeff_ready = rstn && (state_q != PEND);
    assign xfer           = is_coeff_valid && os_coeff_ready && !i_abort;

`ifdef FIR_COEFF_SYMMETRIC_EN
    logic [IDX_W-1:0] mirror_idx;
    assign mirror_idx = IDX_W'(N_TAPS - 1) - idx_q;
`endif

    // IDLE and LOAD share one framing rule since the index is always zero in IDLE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        update_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (i_abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (xfer) begin
                        shadow_d[idx_q] = is32_coeff_data;
`ifdef FIR_COEFF_SYMMETRIC_EN
                        shadow_d[mirror_idx] = is32_coeff_data;
`endif
                        if ((idx_q == LAST_IDX) && is_coeff_last) begin
                            state_d = PEND;
                            idx_d   = '0;
                        end else if ((idx_q != LAST_IDX) && !is_coeff_last) begin
                            state_d = LOAD;
                            idx_d   = idx_q + IDX_ONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end
                end
                PEND: begin
                    if (ce) begin
                        active_d = shadow_q;
                        update_d = 1'b1;
                        cnt_d    = cnt_q + 8'd1;
                        state_d  = IDLE;
                        idx_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            update_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            update_q <= update_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar k = 0; k < N_TAPS; k++) begin : g_out
        assign om_coeff[k*COEFF_W +: COEFF_W] = active_q[k];
    end

    assign o_update      = update_q;
    assign o_load_err    = err_q;
    assign o8_update_cnt = cnt_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized and directed bench for fir_coeff_loader against a set-level reference model.
// The model tracks whole coefficient sets as a queue of beats and expands them into taps on swap.
module tb_fir_coeff_loader;

    localparam int N_TAPS  = 33;
    localparam int COEFF_W = 32;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int H = (N_TAPS + 1) / 2;
`else
    localparam int H = N_TAPS;
`endif

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        ce = 1'b0;
    logic                        is_coeff_valid = 1'b0;
    logic [COEFF_W-1:0]          is32_coeff_data = '0;
    logic                        is_coeff_last = 1'b0;
    logic                        i_abort = 1'b0;
    logic                        os_coeff_ready;
    logic [N_TAPS*COEFF_W-1:0]   om_coeff;
    logic                        o_update;
    logic                        o_load_err;
    logic [7:0]                  o8_update_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: beats of the set in progress, pending flag, active taps, pulses.
    logic [31:0] m_set[$];
    bit          m_pend;
    logic [31:0] m_active [N_TAPS];
    bit          m_upd;
    bit          m_err;
    int          m_cnt;

    fir_coeff_loader #(.N_TAPS(N_TAPS), .COEFF_W(COEFF_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ce              (ce),
        .is_coeff_valid  (is_coeff_valid),
        .os_coeff_ready  (os_coeff_ready),
        .is32_coeff_data (is32_coeff_data),
        .is_coeff_last   (is_coeff_last),
        .i_abort         (i_abort),
        .om_coeff        (om_coeff),
        .o_update        (o_update),
        .o_load_err      (o_load_err),
        .o8_update_cnt   (o8_update_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic int src_beat(input int k);
`ifdef FIR_COEFF_SYMMETRIC_EN
        return (k <= N_TAPS - 1 - k) ? k : N_TAPS - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [N_TAPS*COEFF_W-1:0] model_bank();
        logic [N_TAPS*COEFF_W-1:0] v;
        for (int k = 0; k < N_TAPS; k++) v[k*COEFF_W +: COEFF_W] = m_active[k];
        return v;
    endfunction

    function automatic int first_diff(input logic [N_TAPS*COEFF_W-1:0] a, input logic [N_TAPS*COEFF_W-1:0] b);
        for (int k = 0; k < N_TAPS; k++)
            if (a[k*COEFF_W +: COEFF_W] !== b[k*COEFF_W +: COEFF_W]) return k;
        return -1;
    endfunction

    function automatic logic [31:0] tap(input int k);
        return om_coeff[k*COEFF_W +: COEFF_W];
    endfunction

    // One clock: drive inputs, take the edge, then advance the model with what was driven.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit a, input bit c);
        bit xfer;
        is_coeff_valid  = v;
        is32_coeff_data = d;
        is_coeff_last   = l;
        i_abort         = a;
        ce              = c;
        xfer = v && rstn && !m_pend && !a;
        @(posedge clk);
        #1;
        cyc++;
        m_upd = 0;
        m_err = 0;
        if (!rstn) begin
            m_set.delete();
            m_pend = 0;
            m_cnt  = 0;
            for (int k = 0; k < N_TAPS; k++) m_active[k] = '0;
        end else if (a) begin
            m_set.delete();
            m_pend = 0;
        end else if (m_pend) begin
            if (c) begin
                for (int k = 0; k < N_TAPS; k++) m_active[k] = m_set[src_beat(k)];
                m_upd  = 1;
                m_cnt  = (m_cnt + 1) % 256;
                m_pend = 0;
                m_set.delete();
            end
        end else if (xfer) begin
            m_set.push_back(d);
            if (m_set.size() == H && l) begin
                m_pend = 1;
            end else if (l || m_set.size() == H) begin
                m_err = 1;
                m_set.delete();
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(0, '0, 0, 0, 0);
        step(1, 32'h1234, 0, 0, 1);
        n_tests++;
        if (os_coeff_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_ready got %b exp 0", os_coeff_ready);
        end
        rstn = 1'b1;
        step(0, '0, 0, 0, 0);
        n_tests++;
        if (om_coeff !== '0) begin
            n_fail++; $display("[TB] FAIL reset_bank got tap %0d nonzero exp all zero", first_diff(om_coeff, '0));
        end
        n_tests++;
        if (os_coeff_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL idle_ready got %b exp 1", os_coeff_ready);
        end
        n_tests++;
        if (o8_update_cnt !== 8'd0) begin
            n_fail++; $display("[TB] FAIL reset_cnt got %0d exp 0", o8_update_cnt);
        end
        n_tests++;
        if (o_update !== 1'b0 || o_load_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_pulses got upd %b err %b exp 0 0", o_update, o_load_err);
        end
    endtask

    task automatic test_full_load();
        logic [N_TAPS*COEFF_W-1:0] prev;
        int pulses;
        int bad;
        bit early;
        prev = om_coeff;
        for (int k = 0; k < H; k++)
            step(1, 32'h00010000 * 32'(k), k == H - 1, 0, (cyc % 4) == 0);
        n_tests++;
        if (os_coeff_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL full_ready_after_last got %b exp 0", os_coeff_ready);
        end
        n_tests++;
        if (om_coeff !== prev) begin
            n_fail++; $display("[TB] FAIL full_bank_before_ce changed at tap %0d", first_diff(om_coeff, prev));
        end
        pulses = 0;
        early  = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0, 0, (cyc % 4) == 0);
            if (o_update === 1'b1) pulses++;
            if (pulses == 0 && om_coeff !== prev) early = 1;
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("[TB] FAIL full_update_pulses got %0d exp 1", pulses);
        end
        n_tests++;
        if (early) begin
            n_fail++; $display("[TB] FAIL full_bank_early got changed exp held until update");
        end
        bad = -1;
        for (int k = 0; k < N_TAPS; k++)
            if (bad < 0 && tap(k) !== 32'h00010000 * 32'(src_beat(k))) bad = k;
        n_tests++;
        if (bad >= 0) begin
            n_fail++; $display("[TB] FAIL full_taps tap %0d got %h exp %h", bad, tap(bad), 32'h00010000 * 32'(src_beat(bad)));
        end
        n_tests++;
        if (o8_update_cnt !== 8'd1) begin
            n_fail++; $display("[TB] FAIL full_cnt got %0d exp 1", o8_update_cnt);
        end
    endtask

    task automatic test_short_set();
        logic [N_TAPS*COEFF_W-1:0] prev;
        logic [31:0] first;
        prev = om_coeff;
        for (int k = 0; k < 10; k++) begin
            step(1, $urandom, k == 9, 0, $urandom_range(0, 1) == 1);
            n_tests++;
            if (o_load_err !== (k == 9) || o_update !== 1'b0) begin
                n_fail++; $display("[TB] FAIL short_beat%0d got err %b upd %b exp err %b upd 0", k, o_load_err, o_update, k == 9);
            end
        end
        step(0, '0, 0, 0, 1);
        n_tests++;
        if (o_load_err !== 1'b0 || os_coeff_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL short_after got err %b ready %b exp 0 1", o_load_err, os_coeff_ready);
        end
        n_tests++;
        if (om_coeff !== prev) begin
            n_fail++; $display("[TB] FAIL short_bank_kept changed at tap %0d", first_diff(om_coeff, prev));
        end
        first = $urandom;
        for (int k = 0; k < H; k++) step(1, (k == 0) ? first : $urandom, k == H - 1, 0, 0);
        step(0, '0, 0, 0, 1);
        n_tests++;
        if (o_update !== 1'b1 || tap(0) !== first) begin
            n_fail++; $display("[TB] FAIL short_reload got upd %b tap0 %h exp 1 %h", o_update, tap(0), first);
        end
        n_tests++;
        if (om_coeff !== model_bank()) begin
            n_fail++; $display("[TB] FAIL short_reload_bank tap %0d differs", first_diff(om_coeff, model_bank()));
        end
    endtask

    task automatic test_long_set();
        logic [31:0] extra;
        extra = $urandom;
        for (int k = 0; k <= H; k++) begin
            step(1, (k == H) ? extra : $urandom, 0, 0, 0);
            n_tests++;
            if (o_load_err !== (k == H - 1)) begin
                n_fail++; $display("[TB] FAIL long_err_beat%0d got %b exp %b", k, o_load_err, k == H - 1);
            end
        end
        for (int k = 1; k < H; k++) step(1, $urandom, k == H - 1, 0, 0);
        n_tests++;
        if (os_coeff_ready !== 1'b0 || o_load_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL long_newset_pend got ready %b err %b exp 0 0", os_coeff_ready, o_load_err);
        end
        step(0, '0, 0, 0, 1);
        n_tests++;
        if (tap(0) !== extra || om_coeff !== model_bank()) begin
            n_fail++; $display("[TB] FAIL long_newset_tap0 got %h exp %h", tap(0), extra);
        end
    endtask

    task automatic test_abort_pend();
        logic [N_TAPS*COEFF_W-1:0] prev;
        logic [7:0] prev_cnt;
        prev = om_coeff;
        prev_cnt = o8_update_cnt;
        for (int k = 0; k < H; k++) step(1, $urandom, k == H - 1, 0, 0);
        n_tests++;
        if (os_coeff_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_pend_ready got %b exp 0", os_coeff_ready);
        end
        step(0, '0, 0, 1, 1);
        n_tests++;
        if (o_update !== 1'b0 || os_coeff_ready !== 1'b1 || o_load_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_pend got upd %b ready %b err %b exp 0 1 0", o_update, os_coeff_ready, o_load_err);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0, 1);
            n_tests++;
            if (o_update !== 1'b0 || om_coeff !== prev || o8_update_cnt !== prev_cnt) begin
                n_fail++; $display("[TB] FAIL abort_no_swap%0d got upd %b cnt %0d exp 0 %0d", i, o_update, o8_update_cnt, prev_cnt);
            end
        end
    endtask

    task automatic test_symmetric();
        for (int k = 0; k < H; k++) step(1, 32'(k + 1), k == H - 1, 0, 0);
        step(0, '0, 0, 0, 1);
`ifdef FIR_COEFF_SYMMETRIC_EN
        n_tests++;
        if (tap(0) !== 32'd1 || tap(32) !== 32'd1 || tap(16) !== 32'd17) begin
            n_fail++; $display("[TB] FAIL sym_taps got %0d %0d %0d exp 1 17 1", tap(0), tap(16), tap(32));
        end
`else
        n_tests++;
        if (tap(0) !== 32'd1 || tap(32) !== 32'd33 || tap(16) !== 32'd17) begin
            n_fail++; $display("[TB] FAIL seq_taps got %0d %0d %0d exp 1 17 33", tap(0), tap(16), tap(32));
        end
`endif
    endtask

    task automatic test_random();
        bit v, l, a, c;
        for (int i = 0; i < 1500; i++) begin
            v = $urandom_range(0, 3) != 0;
            l = (m_set.size() == H - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
            a = $urandom_range(0, 59) == 0;
            c = $urandom_range(0, 3) == 0;
            step(v, $urandom, l, a, c);
            n_tests++;
            if (o_update !== m_upd || o_load_err !== m_err) begin
                n_fail++; $display("[TB] FAIL rnd_pulses cyc %0d got upd %b err %b exp %b %b", cyc, o_update, o_load_err, m_upd, m_err);
            end
            n_tests++;
            if (os_coeff_ready !== !m_pend || o8_update_cnt !== 8'(m_cnt)) begin
                n_fail++; $display("[TB] FAIL rnd_status cyc %0d got ready %b cnt %0d exp %b %0d", cyc, os_coeff_ready, o8_update_cnt, !m_pend, m_cnt);
            end
            n_tests++;
            if (om_coeff !== model_bank()) begin
                n_fail++; $display("[TB] FAIL rnd_bank cyc %0d tap %0d got %h exp %h", cyc, first_diff(om_coeff, model_bank()), tap(first_diff(om_coeff, model_bank())), m_active[first_diff(om_coeff, model_bank())]);
            end
        end
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < 5; k++) step(1, $urandom, 0, 0, 0);
        rstn = 1'b0;
        step(1, $urandom, 0, 0, 1);
        n_tests++;
        if (om_coeff !== '0 || o8_update_cnt !== 8'd0 || os_coeff_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset got cnt %0d ready %b bank_tap %0d exp 0 0 -1", o8_update_cnt, os_coeff_ready, first_diff(om_coeff, '0));
        end
        rstn = 1'b1;
        step(0, '0, 0, 0, 0);
        for (int k = 0; k < H; k++) step(1, $urandom, k == H - 1, 0, 0);
        step(0, '0, 0, 0, 1);
        n_tests++;
        if (o_update !== 1'b1 || o8_update_cnt !== 8'd1 || om_coeff !== model_bank()) begin
            n_fail++; $display("[TB] FAIL midreset_reload got upd %b cnt %0d exp 1 1", o_update, o8_update_cnt);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        rstn = 1'b0;
        step(0, '0, 0, 0, 0);
        rstn = 1'b1;
        pulses = 0;
        for (int u = 0; u < 256; u++) begin
            for (int k = 0; k < H; k++) step(1, $urandom, k == H - 1, 0, $urandom_range(0, 1) == 1);
            step(0, '0, 0, 0, 1);
            if (o_update === 1'b1) pulses++;
            if (u == 254) begin
                n_tests++;
                if (o8_update_cnt !== 8'd255) begin
                    n_fail++; $display("[TB] FAIL wrap_cnt255 got %0d exp 255", o8_update_cnt);
                end
            end
        end
        n_tests++;
        if (o8_update_cnt !== 8'd0 || pulses != 256) begin
            n_fail++; $display("[TB] FAIL wrap_cnt0 got cnt %0d pulses %0d exp 0 256", o8_update_cnt, pulses);
        end
    endtask

    initial begin
        m_pend = 0;
        m_upd  = 0;
        m_err  = 0;
        m_cnt  = 0;
        for (int k = 0; k < N_TAPS; k++) m_active[k] = '0;
        test_reset();
        test_full_load();
        test_short_set();
        test_long_set();
        test_abort_pend();
        test_symmetric();
        test_random();
        test_reset_midload();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
